// File: rtl/sid_pkg.sv
// Shared types, default coefficients and saturation helpers for the SID
// external RC output stage.
package sid_pkg;

   typedef logic signed [17:0] sample18_t;
   typedef logic signed [15:0] pcm16_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LP   = 2'd1,
      ST_HP   = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   localparam logic [15:0] LP_COEF_DEF = 16'd45000;
   localparam logic [15:0] HP_COEF_DEF = 16'd100;
   localparam int          FRAC_DEF    = 6;

   localparam logic signed [24:0] PCM_MAX = 25'sd32767;
   localparam logic signed [24:0] PCM_MIN = -25'sd32768;
   localparam logic signed [26:0] ST_MAX  = 27'sd8388607;
   localparam logic signed [26:0] ST_MIN  = -27'sd8388608;

   function automatic pcm16_t clamp16(input logic signed [24:0] v);
      if (v > PCM_MAX)      return 16'sh7fff;
      else if (v < PCM_MIN) return 16'sh8000;
      else                  return v[15:0];
   endfunction

   function automatic logic signed [23:0] clamp24(input logic signed [26:0] v);
      if (v > ST_MAX)      return 24'sh7fffff;
      else if (v < ST_MIN) return 24'sh800000;
      else                 return v[23:0];
   endfunction

endpackage

// File: rtl/sid_onepole.sv
// Combinational one-pole step: state + ((target - state) * k) >>> 16,
// saturated to the 24-bit state range. Shared by the low- and high-pass.
module sid_onepole
   import sid_pkg::*;
(
   input  logic signed [23:0] state,
   input  logic signed [23:0] target,
   input  logic        [15:0] k,
   output logic signed [24:0] diff,
   output logic signed [23:0] next_state
);

   logic signed [41:0] prod;
   logic signed [25:0] step;
   logic signed [26:0] sum;

   always_comb begin
      diff       = 25'(target) - 25'(state);
      // k is unsigned Q0.16, so it enters the multiplier zero-extended.
      prod       = 42'(diff) * 42'($signed({1'b0, k}));
      step       = 26'(prod >>> 16);
      sum        = 27'(state) + 27'(step);
      next_state = clamp24(sum);
   end

endmodule

// File: rtl/sid_ext_filter.sv
// C64 board RC network model: one-pole low-pass then DC-blocking high-pass,
// one shared multiplier sequenced IDLE -> LP -> HP -> OUT, 16-bit PCM out.
module sid_ext_filter
   import sid_pkg::*;
#(
   parameter logic [15:0] LP_COEF = LP_COEF_DEF,
   parameter logic [15:0] HP_COEF = HP_COEF_DEF,
   parameter int          FRAC    = FRAC_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      bypass,
   input  logic      in_valid,
   input  sample18_t audio_in,
   output pcm16_t    out_sample,
   output logic      out_valid,
   input  logic      out_ready,
   output logic      overrun,
   input  logic      clr_overrun,
   output state_e    dbg_state
);

   // out_valid/out_ready: a result transfers on any cycle where both are high;
   // out_valid then drops unless OUT writes a fresh result in that same cycle.

   state_e             state, state_n;
   sample18_t          x;
   logic signed [23:0] lp, dc, xs;
   logic signed [24:0] hp;
   logic signed [23:0] op_state, op_target, op_next;
   logic        [15:0] op_k;
   logic signed [24:0] op_diff;
   pcm16_t             out_next;
   logic               drop_evt, ovw_evt;

   assign dbg_state = state;

   always_comb begin
      xs        = 24'(x) <<< FRAC;
      op_state  = lp;
      op_target = xs;
      op_k      = LP_COEF;
      if (state == ST_HP) begin
         op_state  = dc;
         op_target = lp;
         op_k      = HP_COEF;
      end
   end

   sid_onepole u_onepole (
      .state      (op_state),
      .target     (op_target),
      .k          (op_k),
      .diff       (op_diff),
      .next_state (op_next)
   );

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (in_valid) state_n = ST_LP;
         ST_LP:   state_n = ST_HP;
         ST_HP:   state_n = ST_OUT;
         ST_OUT:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      out_next = bypass ? clamp16(25'(x) >>> 2) : clamp16(hp >>> (FRAC + 2));
      drop_evt = in_valid && (state != ST_IDLE);
      ovw_evt  = (state == ST_OUT) && out_valid && !out_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         x          <= '0;
         lp         <= '0;
         dc         <= '0;
         hp         <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && in_valid) x <= audio_in;
         if (state == ST_LP) lp <= op_next;
         // In HP the shared difference is lp - dc against the pre-update dc.
         if (state == ST_HP) begin
            dc <= op_next;
            hp <= op_diff;
         end
         if (state == ST_OUT) begin
            out_sample <= out_next;
            out_valid  <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop_evt || ovw_evt) overrun <= 1'b1;
         else if (clr_overrun)    overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sid_ext_filter.sv
// Bench for sid_ext_filter: sample-level reference model compared every cycle
// against a default-coefficient instance and a full-coefficient instance.
module tb_sid_ext_filter;
   import sid_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bypass = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic clr_overrun = 1'b0;
   logic signed [17:0] audio_in = '0;
   logic signed [15:0] smp_a, smp_b;
   logic vld_a, vld_b, ovr_a, ovr_b;
   state_e dbg_a, dbg_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sid_ext_filter u_dut (
      .clk(clk), .reset(reset), .bypass(bypass), .in_valid(in_valid),
      .audio_in(audio_in), .out_sample(smp_a), .out_valid(vld_a),
      .out_ready(out_ready), .overrun(ovr_a), .clr_overrun(clr_overrun),
      .dbg_state(dbg_a)
   );

   sid_ext_filter #(.LP_COEF(16'd65535), .HP_COEF(16'd65535)) u_sat (
      .clk(clk), .reset(reset), .bypass(bypass), .in_valid(in_valid),
      .audio_in(audio_in), .out_sample(smp_b), .out_valid(vld_b),
      .out_ready(out_ready), .overrun(ovr_b), .clr_overrun(clr_overrun),
      .dbg_state(dbg_b)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint onepole(input longint s, input longint t, input longint k);
      return sat(s + (((t - s) * k) >>> 16), -8388608, 8388607);
   endfunction

   // Reference model: each accepted sample runs through both filters in one go;
   // the result appears three edges after capture, and the unit is busy until then.
   int     busy = 0;
   bit     m_valid = 0, m_ovr = 0;
   longint lp_a = 0, dc_a = 0, hp_a = 0, lp_b = 0, dc_b = 0, hp_b = 0;
   longint x_cap = 0, m_smp_a = 0, m_smp_b = 0;

   always @(posedge clk or posedge reset) begin
      int ob;
      bit ev;
      longint xs;
      if (reset) begin
         busy = 0; m_valid = 0; m_ovr = 0; x_cap = 0;
         lp_a = 0; dc_a = 0; hp_a = 0; lp_b = 0; dc_b = 0; hp_b = 0;
         m_smp_a = 0; m_smp_b = 0;
      end else begin
         ob = busy;
         ev = 0;
         if (in_valid) begin
            if (ob == 0) begin
               x_cap = longint'(audio_in);
               xs    = x_cap * 64;
               lp_a  = onepole(lp_a, xs, 45000);
               hp_a  = lp_a - dc_a;
               dc_a  = onepole(dc_a, lp_a, 100);
               lp_b  = onepole(lp_b, xs, 65535);
               hp_b  = lp_b - dc_b;
               dc_b  = onepole(dc_b, lp_b, 65535);
               busy  = 3;
            end else begin
               ev = 1;
            end
         end
         if (ob == 1) begin
            if (m_valid && !out_ready) ev = 1;
            m_smp_a = bypass ? sat(x_cap >>> 2, -32768, 32767) : sat(hp_a >>> 8, -32768, 32767);
            m_smp_b = bypass ? sat(x_cap >>> 2, -32768, 32767) : sat(hp_b >>> 8, -32768, 32767);
            m_valid = 1;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
         if (ob != 0) busy = ob - 1;
         if (ev) m_ovr = 1;
         else if (clr_overrun) m_ovr = 0;
      end
   end

   always @(posedge clk) begin
      #3;
      if (!reset) begin
         chk("out_valid", vld_a, m_valid);
         chk("out_valid_sat", vld_b, m_valid);
         chk("overrun", ovr_a, m_ovr);
         chk("overrun_sat", ovr_b, m_ovr);
         chk("out_sample", smp_a, m_smp_a);
         chk("out_sample_sat", smp_b, m_smp_b);
         chk("idle_state", dbg_a == ST_IDLE, busy == 0);
      end
   end

   task automatic send(input int v);
      @(negedge clk);
      in_valid = 1'b1;
      audio_in = 18'(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get(output logic signed [15:0] ra, output logic signed [15:0] rb);
      bit ok = 0;
      ra = '0;
      rb = '0;
      for (int i = 0; i < 10; i++) begin
         if (vld_a) begin
            ok = 1;
            ra = smp_a;
            rb = smp_b;
            break;
         end
         @(negedge clk);
      end
      chk("result_arrives", ok, 1);
   endtask

   logic signed [15:0] ra, rb, first, peak, last;
   int  nvalid;
   bit  saw_max, saw_min;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out_sample", smp_a, 0);
      chk("rst_out_valid", vld_a, 0);
      chk("rst_overrun", ovr_a, 0);
      chk("rst_state_idle", dbg_a == ST_IDLE, 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Step response at +40000
      send(40000);
      get(first, rb);
      chk("step_first_near_6866", (first >= 6865 && first <= 6867), 1);
      repeat (16) @(negedge clk);
      send(40000);
      get(ra, rb);
      chk("step_second_near_9007", (ra >= 9006 && ra <= 9008), 1);
      peak = ra;
      for (int n = 0; n < 298; n++) begin
         repeat (16) @(negedge clk);
         send(40000);
         get(ra, rb);
         if (ra > peak) peak = ra;
      end
      last = ra;
      chk("step_peak_near_10000", (peak > 9500 && peak <= 10000), 1);
      chk("step_decays", (last > 0 && last < peak - 1000), 1);
      repeat (16) @(negedge clk);

      // Bypass
      bypass = 1'b1;
      send(-131072);
      get(ra, rb);
      chk("bypass_min", ra, -32768);
      repeat (8) @(negedge clk);
      send(1000);
      get(ra, rb);
      chk("bypass_1000", ra, 250);
      repeat (8) @(negedge clk);

      // Strobe two clocks after a capture is dropped
      @(negedge clk); in_valid = 1'b1; audio_in = 18'sd2000;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); in_valid = 1'b1; audio_in = 18'sd3000;
      @(negedge clk); in_valid = 1'b0;
      nvalid = 0;
      repeat (10) begin
         @(negedge clk);
         if (vld_a) nvalid++;
      end
      chk("early_one_result", nvalid, 1);
      chk("early_overrun_set", ovr_a, 1);
      @(negedge clk); clr_overrun = 1'b1;
      @(negedge clk); clr_overrun = 1'b0;
      chk("early_overrun_clr", ovr_a, 0);

      // Backpressure across two results
      out_ready = 1'b0;
      send(4000);
      repeat (18) @(negedge clk);
      chk("bp_first_held", smp_a, 1000);
      chk("bp_no_overrun_yet", ovr_a, 0);
      send(8000);
      repeat (6) @(negedge clk);
      chk("bp_second_wins", smp_a, 2000);
      chk("bp_overrun", ovr_a, 1);
      chk("bp_valid_held", vld_a, 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drops", vld_a, 0);
      clr_overrun = 1'b1;
      @(negedge clk); clr_overrun = 1'b0;
      bypass = 1'b0;
      repeat (4) @(negedge clk);

      // Reset while the high-pass step is pending
      @(negedge clk); in_valid = 1'b1; audio_in = 18'sd5000;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_in_hp", dbg_a == ST_HP, 1);
      reset = 1'b1;
      #1;
      chk("midrst_sample", smp_a, 0);
      chk("midrst_valid", vld_a, 0);
      chk("midrst_idle", dbg_a == ST_IDLE, 1);
      @(negedge clk); reset = 1'b0;
      nvalid = 0;
      repeat (8) begin
         @(negedge clk);
         if (vld_a) nvalid++;
      end
      chk("midrst_no_result", nvalid, 0);

      // Saturation with full-scale alternating input
      saw_max = 0;
      saw_min = 0;
      for (int n = 0; n < 40; n++) begin
         send((n % 2 == 0) ? 131071 : -131071);
         get(ra, rb);
         if (rb == 16'sh7fff) saw_max = 1;
         if (rb == 16'sh8000) saw_min = 1;
         repeat (4) @(negedge clk);
      end
      chk("sat_hits_max", saw_max, 1);
      chk("sat_hits_min", saw_min, 1);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sid_ext_filter.md
Name: sid_ext_filter

Overview:
Output stage directly downstream of the SID filter/volume block. It models the C64 board's external RC network: a one-pole low-pass (~16 kHz) followed by a one-pole DC-blocking high-pass (~16 Hz). It consumes the 18-bit signed mixer output once per sample strobe and delivers saturated 16-bit PCM to the audio mux over a valid/ready handshake. One shared multiplier is time-multiplexed through a small FSM.

Parameters:
LP_COEF, 16'd45000, low-pass coefficient k_lp, unsigned Q0.16 (k = 1-exp(-2*pi*fc/fs))
HP_COEF, 16'd100, high-pass (DC tracker) coefficient k_hp, unsigned Q0.16
FRAC, 6, fractional bits carried in filter state registers

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
bypass  in  1  1 = skip both filters; output is clamp16(x>>>2)
in_valid  in  1  one-cycle sample strobe; audio_in valid in same cycle
audio_in  in  18  signed sample from the SID filter/volume stage
out_sample  out  16  signed PCM result
out_valid  out  1  out_sample holds an unconsumed result
out_ready  in  1  consumer accepts out_sample when out_valid && out_ready
overrun  out  1  sticky: a strobe was ignored or an unconsumed result was overwritten
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE, lp=0, dc=0, out_sample=0, out_valid=0, overrun=0.
- State: lp, dc signed 24-bit, value scaled by 2^FRAC. xs = sign-extended audio_in<<<FRAC.
- FSM IDLE -> LP -> HP -> OUT -> IDLE, one cycle each.
- IDLE: on in_valid capture audio_in into x, go LP; otherwise stay.
- LP: lp <= lp + ((xs - lp) * LP_COEF) >>> 16; 25-bit signed difference times 17-bit zero-extended coefficient, 42-bit product, result clamped to 24-bit signed range.
- HP: dc <= dc + ((lp - dc) * HP_COEF) >>> 16, same widths and clamp; hp = lp - dc computed with the pre-update dc, held in a 25-bit register.
- OUT: out_sample <= clamp16(hp >>> (FRAC+2)) (bypass: clamp16(x>>>2)); out_valid <= 1.
- Latency: out_valid rises 4 clocks after the in_valid cycle, counting the capture edge.
- Filter states update every sample regardless of bypass, so no transient when bypass toggles.
- in_valid while FSM != IDLE: the sample is dropped and overrun is set. Minimum strobe spacing is 4 clocks.
- Handshake: when out_valid && out_ready, out_valid falls next cycle unless OUT is writing a new result in that same cycle; the write wins and out_valid stays 1.
- OUT while out_valid=1 and out_ready=0: overwrite out_sample and set overrun.
- clr_overrun together with a new overrun event in the same cycle: set wins.
- clamp16: values above 32767 become 32767; values below -32768 become -32768.
- One multiplier instance; operand muxing is selected by the FSM state.

Decomposition:
- Package sid_pkg: type sample18_t (signed [17:0]), type pcm16_t (signed [15:0]), the clamp16/clamp24 functions, default coefficient constants.
- One natural sub-module: sid_onepole. A combinational one-pole update, state + ((target - state) * k) >>> 16 with clamp, instantiated once and shared by LP and HP through operand muxes.

Test Plan:
- Reset mid-operation: assert reset in the HP state -> all outputs 0, FSM IDLE next cycle, no out_valid.
- Step response: bypass=0, out_ready=1, audio_in=+40000 every 20 clocks.
  - The first output must be near clamp16(((40000<<6)*45000>>16)>>8) = 6866, ±1.
  - Output must rise toward 10000, then decay toward 0 over thousands of samples.
- Bypass: audio_in=-131072 with bypass=1 -> out_sample=-32768. audio_in=1000 -> 250.
- Strobe too early: in_valid at t and t+2 -> one result only, overrun=1; clr_overrun -> 0.
- Backpressure: out_ready=0 over two results -> out_sample holds the second, overrun=1. Raising out_ready clears out_valid next cycle.
- Saturation: alternate full-scale ±131071 input with coefficients set to 65535 -> out_sample never wraps and stays within [-32768, 32767].
